gpio_cfg_sequencer: RTL

Sequencer that pushes every user-project IO pad configuration word out over the serial GPIO configuration chain.
- Triggered by a single pulse, typically a housekeeping register write.
- Fetches each pad's config word from the housekeeping register file through a simple req/ack read port.
- Shifts each word MSB-first onto serial_data_o / serial_clock_o, highest pad first.
- Finishes with a serial_load_o strobe so all pad blocks latch their config simultaneously.

---
 rtl/gpio_cfg_pkg.sv | 24 ++
 rtl/gpio_cfg_clkgen.sv | 31 +++
 rtl/gpio_cfg_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad configuration sequencer.
package gpio_cfg_pkg;

   // Sequencer states, in the order a sequence walks through them.
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SETUP,
      HIGH,
      LOAD,
      DONE
   } cfg_state_e;

   localparam int NUM_PADS_DEF = 38;   // MPRJ_IO_PADS
   localparam int CFG_BITS_DEF = 13;
   localparam int CLK_DIV_DEF  = 2;
   localparam int DIV_CNT_W    = 4;    // half-period counter, CLK_DIV 1..15

   // Index width that never collapses to zero bits for tiny chains.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gpio_cfg_clkgen.sv
// Half-period timer: tick is high in the last cycle of every CLK_DIV-cycle
// window. Restarts from zero whenever the sequencer changes state so each
// state's dwell is measured from its first cycle.
module gpio_cfg_clkgen
   import gpio_cfg_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic clear,
   output logic tick
);

   localparam logic [DIV_CNT_W-1:0] LAST = DIV_CNT_W'(CLK_DIV - 1);

   logic [DIV_CNT_W-1:0] cnt;

   assign tick = (cnt == LAST);

   // Count up to LAST and wrap; a state change forces a fresh window.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clear)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// Pushes every pad configuration word out over the serial GPIO chain:
// fetch a word from the register file, shift it MSB-first, highest pad
// first, then strobe serial_load_o so every pad latches at once.
module gpio_cfg_sequencer
   import gpio_cfg_pkg::*;
#(
   parameter int NUM_PADS = NUM_PADS_DEF,
   parameter int CFG_BITS = CFG_BITS_DEF,
   parameter int CLK_DIV  = CLK_DIV_DEF
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   input  logic                        start_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        cfg_rd_req_o,
   output logic [idx_w(NUM_PADS)-1:0]  cfg_rd_adr_o,
   input  logic                        cfg_rd_ack_i,
   input  logic [CFG_BITS-1:0]         cfg_rd_dat_i,
   output logic                        serial_clock_o,
   output logic                        serial_data_o,
   output logic                        serial_load_o,
   output logic                        serial_resetn_o
);

   localparam int AW = idx_w(NUM_PADS);
   localparam int BW = idx_w(CFG_BITS);
   localparam logic [AW-1:0] PAD_LAST = AW'(NUM_PADS - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);

   cfg_state_e          state, state_nxt;
   logic [AW-1:0]       pad_idx, pad_nxt;
   logic [BW-1:0]       bit_cnt, bit_nxt;
   logic [CFG_BITS-1:0] shreg, shreg_nxt;
   logic                tick;
   logic                state_chg;

   assign state_chg = (state_nxt != state);

   gpio_cfg_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .clear    (state_chg),
      .tick     (tick)
   );

   // State register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and datapath update: walks pads high to low, bits MSB first.
   always_comb begin
      state_nxt = state;
      pad_nxt   = pad_idx;
      bit_nxt   = bit_cnt;
      shreg_nxt = shreg;
      case (state)
         IDLE: begin
            if (start_i) begin
               pad_nxt   = PAD_LAST;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (cfg_rd_ack_i) begin
               shreg_nxt = cfg_rd_dat_i;
               bit_nxt   = BIT_LAST;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (tick)
               state_nxt = HIGH;
         end
         HIGH: begin
            if (tick) begin
               shreg_nxt = shreg << 1;
               if (bit_cnt != '0) begin
                  bit_nxt   = bit_cnt - 1'b1;
                  state_nxt = SETUP;
               end else if (pad_idx != '0) begin
                  pad_nxt   = pad_idx - 1'b1;
                  state_nxt = FETCH;
               end else begin
                  state_nxt = LOAD;
               end
            end
         end
         LOAD: begin
            if (tick)
               state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         pad_idx <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         pad_idx <= pad_nxt;
         bit_cnt <= bit_nxt;
         shreg   <= shreg_nxt;
      end
   end

   // Outputs are registered from the next state so they line up with the
   // state they describe, with no combinational path to the pads.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         cfg_rd_req_o    <= 1'b0;
         cfg_rd_adr_o    <= '0;
         serial_clock_o  <= 1'b0;
         serial_data_o   <= 1'b0;
         serial_load_o   <= 1'b0;
         serial_resetn_o <= 1'b0;
      end else begin
         busy_o          <= (state_nxt == FETCH) || (state_nxt == SETUP) ||
                            (state_nxt == HIGH)  || (state_nxt == LOAD);
         done_o          <= (state_nxt == DONE);
         cfg_rd_req_o    <= (state_nxt == FETCH);
         cfg_rd_adr_o    <= pad_nxt;
         serial_clock_o  <= (state_nxt == HIGH);
         serial_data_o   <= ((state_nxt == SETUP) || (state_nxt == HIGH)) ?
                            shreg_nxt[CFG_BITS-1] : 1'b0;
         serial_load_o   <= (state_nxt == LOAD);
         serial_resetn_o <= 1'b1;
      end
   end

endmodule
